// File: rtl/fft_r2sdf_stage_if.sv
// ---------------------------------------------------------------------------
// fft_r2sdf_stage_if
// Streaming bus of one radix-2 single-path delay-feedback FFT stage.
//   in_valid        : input sample present this cycle
//   in_r / in_i     : signed Q1.15 input sample
//   out_valid       : out_r/out_i/tw_idx/out_sop valid this cycle
//   out_r / out_i   : signed butterfly result for the downstream multiplier
//   tw_idx          : twiddle index, 0 = unity twiddle
//   out_sop         : first output of a frame
// The stage connects through the slave modport; the source/sink side
// connects through the master modport.
// ---------------------------------------------------------------------------
interface fft_r2sdf_stage_if #(
  parameter int IDXW = 3
);
  logic                   in_valid;
  logic signed [15:0]     in_r;
  logic signed [15:0]     in_i;
  logic                   out_valid;
  logic signed [15:0]     out_r;
  logic signed [15:0]     out_i;
  logic        [IDXW-1:0] tw_idx;
  logic                   out_sop;

  modport master (
    output in_valid, in_r, in_i,
    input  out_valid, out_r, out_i, tw_idx, out_sop
  );

  modport slave (
    input  in_valid, in_r, in_i,
    output out_valid, out_r, out_i, tw_idx, out_sop
  );
endinterface

// File: rtl/fft_r2sdf_stage.sv
// ---------------------------------------------------------------------------
// fft_r2sdf_stage
// One radix-2 SDF (single-path delay feedback) FFT stage.
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : fft_r2sdf_stage_if.slave (in_valid/in_r/in_i in,
//            out_valid/out_r/out_i/tw_idx/out_sop out)
// Frame = 2*DEPTH samples. First half fills the delay line while the
// previous frame's differences drain out; second half forms sums
// (emitted) and differences (stored back). Outputs are registered,
// latency 1 from the accepted input.
// ---------------------------------------------------------------------------
module fft_r2sdf_stage #(
  parameter int DEPTH = 8,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  fft_r2sdf_stage_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * DEPTH - 1);

  // state
  logic [CW-1:0]          r_cnt;
  logic                   r_primed;
  logic [31:0]            r_dly [DEPTH];
  logic                   r_out_valid;
  logic signed [15:0]     r_out_r;
  logic signed [15:0]     r_out_i;
  logic [IDXW-1:0]        r_tw_idx;
  logic                   r_out_sop;

  // datapath
  logic [AW-1:0]          w_addr;
  logic                   w_bf;
  logic                   w_first_bf;
  logic                   w_acc;
  logic [31:0]            w_d;
  logic signed [15:0]     w_dr, w_di;
  logic signed [16:0]     w_sum_r, w_sum_i, w_dif_r, w_dif_i;
  logic signed [15:0]     w_s_r, w_s_i, w_t_r, w_t_i;
  logic [31:0]            w_wr_data;

  assign w_addr     = r_cnt[AW-1:0];            // cnt mod DEPTH
  assign w_bf       = (r_cnt >= CNT_HALF);      // butterfly half of the frame
  assign w_first_bf = (r_cnt == CNT_HALF);
  // reset wins over an input presented in the same cycle
  assign w_acc      = bus.in_valid & ~reset;

  assign w_d  = r_dly[w_addr];
  assign w_dr = w_d[31:16];
  assign w_di = w_d[15:0];

  // 17-bit sums can't overflow; >>>1 then truncate always fits 16 bits
  assign w_sum_r = {w_dr[15], w_dr} + {bus.in_r[15], bus.in_r};
  assign w_sum_i = {w_di[15], w_di} + {bus.in_i[15], bus.in_i};
  assign w_dif_r = {w_dr[15], w_dr} - {bus.in_r[15], bus.in_r};
  assign w_dif_i = {w_di[15], w_di} - {bus.in_i[15], bus.in_i};

  assign w_s_r = 16'(w_sum_r >>> 1);
  assign w_s_i = 16'(w_sum_i >>> 1);
  assign w_t_r = 16'(w_dif_r >>> 1);
  assign w_t_i = 16'(w_dif_i >>> 1);

  // fill half stores the raw input, butterfly half feeds back the difference
  assign w_wr_data = w_bf ? {w_t_r, w_t_i} : {bus.in_r, bus.in_i};

  // Delay line: deliberately unreset; stale entries are never flagged valid
  // because primed stays low until the first butterfly.
  always_ff @(posedge clk) begin
    if (w_acc) r_dly[w_addr] <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_primed    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_i     <= '0;
      r_tw_idx    <= '0;
      r_out_sop   <= 1'b0;
    end else begin
      // a bubble drops valid but leaves the data registers untouched
      r_out_valid <= bus.in_valid & (r_primed | w_bf);
      if (bus.in_valid) begin
        r_cnt     <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        if (w_first_bf) r_primed <= 1'b1;
        r_out_sop <= w_first_bf;
        if (w_bf) begin
          r_out_r  <= w_s_r;
          r_out_i  <= w_s_i;
          r_tw_idx <= '0;
        end else begin
          r_out_r  <= w_dr;
          r_out_i  <= w_di;
          r_tw_idx <= IDXW'(w_addr);
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_r     = r_out_r;
  assign bus.out_i     = r_out_i;
  assign bus.tw_idx    = r_tw_idx;
  assign bus.out_sop   = r_out_sop;

endmodule

// File: tb/tb_fft_r2sdf_stage.sv
// Bench for fft_r2sdf_stage at DEPTH=4: table-driven ramp vectors,
// hand sequences for corner cases, and random traffic against a
// frame-level reference model built from a history of accepted samples.
module tb_fft_r2sdf_stage;
  localparam int D = 4;
  localparam int IW = 2;

  logic clk;
  logic reset;
  fft_r2sdf_stage_if #(.IDXW(IW)) bus();

  fft_r2sdf_stage #(.DEPTH(D), .IDXW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int hist_r[$];
  int hist_i[$];
  bit m_valid, m_sop, m_known;
  int m_r, m_i, m_tw;

  // observed valid outputs (for sequence-level checks)
  int obs_r[$];
  int obs_sop[$];

  typedef struct {
    bit v; int r; int i;
    bit ev; int er; int ei; int etw; bit esop;
  } vec_t;
  vec_t tbl[12];

  function automatic int s16(input int x);
    logic [15:0] t;
    t = x[15:0];
    return int'($signed(t));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: sample n of the stream sits at position p of frame n/(2D).
  // Second half emits pairwise averages with the first half; the first
  // half of the next frame emits the previous frame's pairwise half-differences.
  task automatic model_step(input bit v, input int r, input int i);
    int n, p, b;
    if (!v) begin
      m_valid = 1'b0;
      return;
    end
    n = hist_r.size();
    hist_r.push_back(s16(r));
    hist_i.push_back(s16(i));
    p = n % (2 * D);
    b = n - p;
    if (p >= D) begin
      m_r = (hist_r[b + p - D] + hist_r[b + p]) >>> 1;
      m_i = (hist_i[b + p - D] + hist_i[b + p]) >>> 1;
      m_tw = 0; m_sop = (p == D); m_valid = 1'b1; m_known = 1'b1;
    end else if (b > 0) begin
      m_r = (hist_r[b - 2 * D + p] - hist_r[b - D + p]) >>> 1;
      m_i = (hist_i[b - 2 * D + p] - hist_i[b - D + p]) >>> 1;
      m_tw = p; m_sop = 1'b0; m_valid = 1'b1; m_known = 1'b1;
    end else begin
      m_tw = p; m_sop = 1'b0; m_valid = 1'b0; m_known = 1'b0;
    end
  endtask

  task automatic step(input bit v, input int r, input int i);
    reset        = 1'b0;
    bus.in_valid = v;
    bus.in_r     = 16'(r);
    bus.in_i     = 16'(i);
    @(posedge clk);
    #1;
    model_step(v, r, i);
    chk("out_valid", int'(bus.out_valid), int'(m_valid));
    chk("tw_idx", int'(bus.tw_idx), m_tw);
    chk("out_sop", int'(bus.out_sop), int'(m_sop));
    if (m_known) begin
      chk("out_r", int'(bus.out_r), m_r);
      chk("out_i", int'(bus.out_i), m_i);
    end
    if (bus.out_valid) begin
      obs_r.push_back(int'(bus.out_r));
      obs_sop.push_back(int'(bus.out_sop));
    end
  endtask

  // reset with in_valid high to exercise reset dominance
  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_r     = 16'($urandom);
    bus.in_i     = 16'($urandom);
    @(posedge clk);
    #1;
    hist_r.delete(); hist_i.delete();
    m_valid = 0; m_sop = 0; m_known = 1; m_r = 0; m_i = 0; m_tw = 0;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_sop", int'(bus.out_sop), 0);
    chk("rst_r", int'(bus.out_r), 0);
    chk("rst_i", int'(bus.out_i), 0);
    chk("rst_tw", int'(bus.tw_idx), 0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    obs_r.delete(); obs_sop.delete();
  endtask

  task automatic chk_seq(input string name, input int exp_r[], input int sop_at[]);
    chk({name, "_count"}, obs_r.size(), exp_r.size());
    for (int k = 0; k < exp_r.size() && k < obs_r.size(); k++) begin
      chk({name, "_r"}, obs_r[k], exp_r[k]);
      chk({name, "_sop"}, obs_sop[k], sop_at[k]);
    end
  endtask

  initial begin
    int ramp_exp[];
    int ramp_sop[];
    int b2b_exp[];
    int b2b_sop[];
    int ext_d[4];
    int ext_x[4];
    int ext_s[4];
    int ext_t[4];

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_r = '0;
    bus.in_i = '0;

    // ramp 1..8 then 4 zeros with hand-derived expectations
    for (int k = 0; k < 12; k++) begin
      tbl[k].v = 1'b1;
      tbl[k].r = (k < 8) ? k + 1 : 0;
      tbl[k].i = 0;
      tbl[k].ev = (k >= 4);
      tbl[k].ei = 0;
      tbl[k].er = (k < 8) ? k - 1 : -2;   // sums 3..6 (k=4..7)
      tbl[k].etw = (k < 8) ? 0 : k - 8;
      tbl[k].esop = (k == 4);
    end

    ramp_exp = '{3, 4, 5, 6, -2, -2, -2, -2};
    ramp_sop = '{1, 0, 0, 0, 0, 0, 0, 0};
    b2b_exp  = '{3, 4, 5, 6, -2, -2, -2, -2, 11, 12, 13, 14, -2, -2, -2, -2};
    b2b_sop  = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    ext_d = '{32767, -32768, -1, 0};
    ext_x = '{32767, 32767, 0, 0};
    ext_s = '{32767, -1, -1, 0};
    ext_t = '{0, -32768, -1, 0};

    do_reset();
    do_reset();

    // 1) table ramp
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].v, tbl[k].r, tbl[k].i);
      chk("tbl_valid", int'(bus.out_valid), int'(tbl[k].ev));
      if (tbl[k].ev) begin
        chk("tbl_r", int'(bus.out_r), tbl[k].er);
        chk("tbl_i", int'(bus.out_i), tbl[k].ei);
        chk("tbl_tw", int'(bus.tw_idx), tbl[k].etw);
        chk("tbl_sop", int'(bus.out_sop), int'(tbl[k].esop));
      end
    end

    // 2) extremes: full-scale sums/differences and floor rounding
    do_reset();
    for (int k = 0; k < 4; k++) step(1, ext_d[k], ext_d[k]);
    for (int k = 0; k < 4; k++) begin
      step(1, ext_x[k], ext_x[k]);
      chk("ext_s_r", int'(bus.out_r), ext_s[k]);
      chk("ext_s_i", int'(bus.out_i), ext_s[k]);
    end
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0);
      chk("ext_t_r", int'(bus.out_r), ext_t[k]);
      chk("ext_t_tw", int'(bus.tw_idx), k);
    end

    // 3) ramp with a bubble after every input
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(1, (k < 8) ? k + 1 : 0, 0);
      step(0, int'($urandom), int'($urandom));
      chk("bubble_valid", int'(bus.out_valid), 0);
    end
    chk_seq("bubble", ramp_exp, ramp_sop);

    // 4) reset after 6 inputs, then the ramp again
    do_reset();
    for (int k = 0; k < 6; k++) step(1, 100 + k, -k);
    do_reset();
    for (int k = 0; k < 12; k++) step(1, (k < 8) ? k + 1 : 0, 0);
    chk_seq("midrst", ramp_exp, ramp_sop);

    // 5) back-to-back frames 1..8, 9..16, then flush
    do_reset();
    for (int k = 0; k < 20; k++) step(1, (k < 16) ? k + 1 : 0, 0);
    chk_seq("b2b", b2b_exp, b2b_sop);

    // 6) random traffic, bubbles and occasional resets
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, int'($urandom), int'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
